// File: rtl/pht_update_scheduler.sv
// Single write-port sequencer for the PHT counter RAM: runs the init sweep, then
// serialises per-lane branch updates through an in-order overflow FIFO.
module pht_update_scheduler #(
    parameter int ENTRY_NUM   = 2048,
    parameter int INDEX_WIDTH = 11,
    parameter int ENTRY_WIDTH = 2,
    parameter int REQ_NUM     = 2,
    parameter int QUEUE_DEPTH = 8,
    parameter int INIT_VALUE  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_start,
    input  logic [REQ_NUM-1:0]             req_valid,
    input  logic [REQ_NUM*INDEX_WIDTH-1:0] req_index,
    input  logic [REQ_NUM*ENTRY_WIDTH-1:0] req_value,
    output logic                           pht_we,
    output logic [INDEX_WIDTH-1:0]         pht_wa,
    output logic [ENTRY_WIDTH-1:0]         pht_wv,
    output logic                           busy_init,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic [15:0]                    drop_count
);

    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                   r_state;
    logic [INDEX_WIDTH-1:0]   r_sweep_idx;
    logic                     r_pht_we;
    logic [INDEX_WIDTH-1:0]   r_pht_wa;
    logic [ENTRY_WIDTH-1:0]   r_pht_wv;
    logic                     r_busy_init;
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;
    logic [15:0]              r_drop_count;
    logic [INDEX_WIDTH-1:0]   r_q_index [QUEUE_DEPTH];
    logic [ENTRY_WIDTH-1:0]   r_q_value [QUEUE_DEPTH];

    logic                     w_run;
    logic                     w_pop;
    logic [CNT_W-1:0]         w_capacity;
    logic                     w_direct_valid;
    logic [LANE_W-1:0]        w_direct_lane;
    logic [REQ_NUM-1:0]       w_push;
    logic [PTR_W-1:0]         w_push_off [REQ_NUM];
    logic [CNT_W-1:0]         w_push_num;
    logic [CNT_W-1:0]         w_drop_num;
    logic [16:0]              w_drop_sum;
    logic [15:0]              w_drop_next;
    logic [INDEX_WIDTH-1:0]   w_direct_index;
    logic [ENTRY_WIDTH-1:0]   w_direct_value;

    // init_start wins over any same-edge update: those lanes are neither written nor counted.
    assign w_run      = (r_state == S_RUN) && !init_start;
    assign w_pop      = w_run && (r_count != '0);
    assign w_capacity = CNT_W'(QUEUE_DEPTH) - r_count + CNT_W'(w_pop);

    // Lane allocation: the queue head has priority over fresh lanes, so the lowest
    // lane only bypasses the FIFO when it is empty; the rest fill free slots in lane order.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_direct_valid = 1'b0;
        w_direct_lane  = '0;
        w_push         = '0;
        w_push_num     = '0;
        w_drop_num     = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_push_off[i] = '0;
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_run && req_valid[i]) begin
                if (!w_pop && !w_direct_valid) begin
                    w_direct_valid = 1'b1;
                    w_direct_lane  = LANE_W'(i);
                end else if (w_push_num < w_capacity) begin
                    w_push[i]     = 1'b1;
                    w_push_off[i] = PTR_W'(w_push_num);
                    w_push_num    = w_push_num + CNT_W'(1);
                end else begin
                    w_drop_num = w_drop_num + CNT_W'(1);
                end
            end
        end
    end

    assign w_direct_index = req_index[w_direct_lane*INDEX_WIDTH +: INDEX_WIDTH];
    assign w_direct_value = req_value[w_direct_lane*ENTRY_WIDTH +: ENTRY_WIDTH];
    assign w_drop_sum     = 17'(r_drop_count) + 17'(w_drop_num);
    assign w_drop_next    = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_INIT;
            r_sweep_idx  <= '0;
            r_pht_we     <= 1'b0;
            r_pht_wa     <= '0;
            r_pht_wv     <= '0;
            r_busy_init  <= 1'b1;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (init_start) begin
                        r_pht_we    <= 1'b0;
                        r_sweep_idx <= '0;
                    end else begin
                        r_pht_we    <= 1'b1;
                        r_pht_wa    <= r_sweep_idx;
                        r_pht_wv    <= ENTRY_WIDTH'(INIT_VALUE);
                        r_sweep_idx <= r_sweep_idx + INDEX_WIDTH'(1);
                        if (r_sweep_idx == INDEX_WIDTH'(ENTRY_NUM - 1)) begin
                            r_state     <= S_RUN;
                            r_busy_init <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (init_start) begin
                        r_state     <= S_INIT;
                        r_busy_init <= 1'b1;
                        r_sweep_idx <= '0;
                        r_pht_we    <= 1'b0;
                        r_head      <= '0;
                        r_tail      <= '0;
                        r_count     <= '0;
                    end else begin
                        if (w_pop) begin
                            r_pht_we <= 1'b1;
                            r_pht_wa <= r_q_index[r_head];
                            r_pht_wv <= r_q_value[r_head];
                            r_head   <= r_head + PTR_W'(1);
                        end else if (w_direct_valid) begin
                            r_pht_we <= 1'b1;
                            r_pht_wa <= w_direct_index;
                            r_pht_wv <= w_direct_value;
                        end else begin
                            r_pht_we <= 1'b0;
                        end
                        r_tail       <= r_tail + PTR_W'(w_push_num);
                        r_count      <= r_count - CNT_W'(w_pop) + w_push_num;
                        r_drop_count <= w_drop_next;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by r_count, so stale slots are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_push[i]) begin
                r_q_index[r_tail + w_push_off[i]] <= req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
                r_q_value[r_tail + w_push_off[i]] <= req_value[i*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
        end
    end

    assign pht_we      = r_pht_we;
    assign pht_wa      = r_pht_wa;
    assign pht_wv      = r_pht_wv;
    assign busy_init   = r_busy_init;
    assign queue_count = r_count;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler with a 16-entry table, 2 lanes and a 4-deep FIFO.
// Inputs change and outputs are sampled on the falling edge.
module tb_pht_update_scheduler;

    localparam int EN = 16;
    localparam int IW = 4;
    localparam int EW = 2;
    localparam int RN = 2;
    localparam int QD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             init_start;
    logic [RN-1:0]    req_valid;
    logic [RN*IW-1:0] req_index;
    logic [RN*EW-1:0] req_value;
    logic             pht_we;
    logic [IW-1:0]    pht_wa;
    logic [EW-1:0]    pht_wv;
    logic             busy_init;
    logic [2:0]       queue_count;
    logic [15:0]      drop_count;

    int n_cmp = 0;
    int n_mis = 0;

    pht_update_scheduler #(
        .ENTRY_NUM  (EN),
        .INDEX_WIDTH(IW),
        .ENTRY_WIDTH(EW),
        .REQ_NUM    (RN),
        .QUEUE_DEPTH(QD),
        .INIT_VALUE (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .req_valid  (req_valid),
        .req_index  (req_index),
        .req_value  (req_value),
        .pht_we     (pht_we),
        .pht_wa     (pht_wa),
        .pht_wv     (pht_wv),
        .busy_init  (busy_init),
        .queue_count(queue_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [1:0] v, input int i0, input int e0, input int i1, input int e1);
        req_valid = v;
        req_index = {IW'(i1), IW'(i0)};
        req_value = {EW'(e1), EW'(e0)};
    endtask

    task automatic check_wr(input string tag, input int wa, input int wv);
        check({tag, " we"}, 32'(pht_we), 32'd1);
        check({tag, " wa"}, 32'(pht_wa), 32'(wa));
        check({tag, " wv"}, 32'(pht_wv), 32'(wv));
    endtask

    // One RUN cycle: drive lanes, clock, then expect a write plus queue/drop state.
    task automatic cyc(input string tag, input logic [1:0] v, input int i0, input int e0,
                       input int i1, input int e1, input int wa, input int wv,
                       input int qc, input int dc);
        set_req(v, i0, e0, i1, e1);
        step();
        check_wr(tag, wa, wv);
        check({tag, " qc"}, 32'(queue_count), 32'(qc));
        check({tag, " drop"}, 32'(drop_count), 32'(dc));
    endtask

    initial begin
        rst        = 1'b1;
        init_start = 1'b0;
        set_req(2'b00, 0, 0, 0, 0);

        #2;
        check("rst we", 32'(pht_we), 32'd0);
        check("rst wa", 32'(pht_wa), 32'd0);
        check("rst wv", 32'(pht_wv), 32'd0);
        check("rst busy", 32'(busy_init), 32'd1);
        check("rst qc", 32'(queue_count), 32'd0);
        check("rst drop", 32'(drop_count), 32'd0);

        // Post-reset sweep: 16 consecutive writes of the weakly-taken value.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < EN; k++) begin
            step();
            check_wr($sformatf("sweep1 %0d", k), k, 2);
            check($sformatf("sweep1 busy %0d", k), 32'(busy_init), (k == EN - 1) ? 32'd0 : 32'd1);
        end
        step();
        check("idle we", 32'(pht_we), 32'd0);
        check("idle wa hold", 32'(pht_wa), 32'd15);
        check("idle qc", 32'(queue_count), 32'd0);

        // Two lanes into an empty FIFO: lane 0 bypasses, lane 1 queues.
        set_req(2'b11, 5, 3, 9, 0);
        step();
        set_req(2'b00, 0, 0, 0, 0);
        check_wr("pair lane0", 5, 3);
        check("pair qc1", 32'(queue_count), 32'd1);
        step();
        check_wr("pair lane1", 9, 0);
        check("pair qc0", 32'(queue_count), 32'd0);
        step();
        check("pair idle we", 32'(pht_we), 32'd0);
        check("pair idle wa", 32'(pht_wa), 32'd9);

        // Three cycles of dual requests drain one per cycle in arrival order.
        cyc("burst c1", 2'b11, 1, 1, 2, 2, 1, 1, 1, 0);
        cyc("burst c2", 2'b11, 3, 3, 4, 0, 2, 2, 2, 0);
        cyc("burst c3", 2'b11, 6, 1, 7, 2, 3, 3, 3, 0);
        cyc("burst d1", 2'b00, 0, 0, 0, 0, 4, 0, 2, 0);
        cyc("burst d2", 2'b00, 0, 0, 0, 0, 6, 1, 1, 0);
        cyc("burst d3", 2'b00, 0, 0, 0, 0, 7, 2, 0, 0);

        // Fill to full, then a full queue with a pop accepts only lane 0.
        cyc("fill c1", 2'b11, 8, 1, 9, 2, 8, 1, 1, 0);
        cyc("fill c2", 2'b11, 10, 3, 11, 0, 9, 2, 2, 0);
        cyc("fill c3", 2'b11, 12, 1, 13, 2, 10, 3, 3, 0);
        cyc("fill c4", 2'b11, 14, 3, 15, 0, 11, 0, 4, 0);
        cyc("full drop1", 2'b11, 0, 1, 1, 2, 12, 1, 4, 1);

        // Preload the drop counter just below its ceiling to exercise saturation.
        force dut.r_drop_count = 16'hFFFE;
        #1;
        release dut.r_drop_count;
        cyc("sat reach", 2'b11, 2, 3, 3, 0, 13, 2, 4, 16'hFFFF);
        cyc("sat hold", 2'b11, 4, 1, 5, 2, 14, 3, 4, 16'hFFFF);
        cyc("pre init", 2'b00, 0, 0, 0, 0, 15, 0, 3, 16'hFFFF);

        // init_start with three queued entries flushes them and restarts the sweep.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        check("init we", 32'(pht_we), 32'd0);
        check("init qc", 32'(queue_count), 32'd0);
        check("init busy", 32'(busy_init), 32'd1);
        check("init drop kept", 32'(drop_count), 32'hFFFF);
        set_req(2'b11, 3, 1, 7, 3);
        for (int k = 0; k < EN; k++) begin
            step();
            check_wr($sformatf("sweep2 %0d", k), k, 2);
            check($sformatf("sweep2 qc %0d", k), 32'(queue_count), 32'd0);
        end
        set_req(2'b00, 0, 0, 0, 0);
        check("sweep2 busy end", 32'(busy_init), 32'd0);
        step();
        check("post sweep2 we", 32'(pht_we), 32'd0);
        check("post sweep2 qc", 32'(queue_count), 32'd0);

        // Async reset mid-sweep at sweep_idx 7, asserted while the clock is low.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        check("sweep3 start we", 32'(pht_we), 32'd0);
        for (int k = 0; k < 7; k++) begin
            step();
            check_wr($sformatf("sweep3 %0d", k), k, 2);
        end
        set_req(2'b11, 1, 1, 2, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async we", 32'(pht_we), 32'd0);
        check("async wa", 32'(pht_wa), 32'd0);
        check("async wv", 32'(pht_wv), 32'd0);
        check("async busy", 32'(busy_init), 32'd1);
        check("async qc", 32'(queue_count), 32'd0);
        check("async drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < EN; k++) begin
            step();
            check_wr($sformatf("sweep4 %0d", k), k, 2);
            check($sformatf("sweep4 drop %0d", k), 32'(drop_count), 32'd0);
        end
        set_req(2'b00, 0, 0, 0, 0);
        step();
        check("final we", 32'(pht_we), 32'd0);
        check("final qc", 32'(queue_count), 32'd0);
        check("final drop", 32'(drop_count), 32'd0);
        check("final busy", 32'(busy_init), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
